// File: rtl/lfsr_prng.sv
// Fibonacci-style LFSR pseudo-random generator with a bounded-range draw engine.
// Draws use rejection sampling against a power-of-two mask, with a subtract fallback.
module lfsr_prng #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
    parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
    parameter int unsigned      OUT_W     = 8,
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] range,
    output logic [WIDTH-1:0] state,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value
);

    typedef enum logic {StIdle, StDraw} fsm_e;

    localparam logic [3:0] LastTry = 4'(MAX_TRIES - 1);

    fsm_e             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [OUT_W-1:0] rng_q, rng_d;
    logic [OUT_W-1:0] value_q, value_d;
    logic [3:0]       tries_q, tries_d;
    logic             valid_q, valid_d;

    logic             fb;
    logic [OUT_W-1:0] rng_m1;
    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] cand;
    logic             accept;

    always_comb begin
        fb      = ^(state_q & TAPS);
        state_d = state_q;
        if (load) begin
            state_d = (seed_in == '0) ? SEED : seed_in;
        end else if (en || (fsm_q == StDraw)) begin
            // An all-zero state would lock up; restart from the seed instead.
            state_d = (state_q == '0) ? SEED : {state_q[WIDTH-2:0], fb};
        end
    end

    // Smear the MSB of (range-1) downward to get the smallest covering mask.
    always_comb begin
        rng_m1 = rng_q - 1'b1;
        mask   = rng_m1;
        for (int i = int'(OUT_W) - 2; i >= 0; i--) begin
            mask[i] = mask[i] | mask[i+1];
        end
        if (rng_q == '0) begin
            mask = '1;
        end
    end

    assign cand   = state_q[OUT_W-1:0] & mask;
    assign accept = (rng_q == '0) || (cand < rng_q);

    always_comb begin
        fsm_d   = fsm_q;
        rng_d   = rng_q;
        tries_d = tries_q;
        value_d = value_q;
        valid_d = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (req) begin
                    rng_d   = range;
                    tries_d = '0;
                    fsm_d   = StDraw;
                end
            end
            StDraw: begin
                if (accept) begin
                    value_d = cand;
                    valid_d = 1'b1;
                    fsm_d   = StIdle;
                end else if (tries_q == LastTry) begin
                    // cand < 2*rng_q here, so the difference is always in range.
                    value_d = cand - rng_q;
                    valid_d = 1'b1;
                    fsm_d   = StIdle;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= StIdle;
            state_q <= SEED;
            rng_q   <= '0;
            value_q <= '0;
            tries_q <= '0;
            valid_q <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rng_q   <= rng_d;
            value_q <= value_d;
            tries_q <= tries_d;
            valid_q <= valid_d;
        end
    end

    assign state = state_q;
    assign busy  = (fsm_q == StDraw);
    assign valid = valid_q;
    assign value = value_q;

endmodule

// File: tb/tb_lfsr_prng.sv
// Bench for lfsr_prng: two instances (MAX_TRIES 4 and 1) share stimulus and are
// compared every cycle against a draw-outcome model, plus hand-computed vectors.
module tb_lfsr_prng;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic        req = 1'b0;
    logic [15:0] seed_in = 16'h0;
    logic [7:0]  range = 8'h0;

    logic [15:0] state0, state1;
    logic        busy0, busy1, valid0, valid1;
    logic [7:0]  value0, value1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lfsr_prng dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
        .req(req), .range(range), .state(state0), .busy(busy0), .valid(valid0),
        .value(value0)
    );

    lfsr_prng #(.MAX_TRIES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .seed_in(seed_in),
        .req(req), .range(range), .state(state1), .busy(busy1), .valid(valid1),
        .value(value1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        if (s == 16'h0) return SEED;
        return {s[14:0], ^(s & TAPS)};
    endfunction

    // Smallest 2^k - 1 covering range-1; full mask for range 0.
    function automatic logic [7:0] draw_mask(input logic [7:0] r);
        int p;
        p = 1;
        if (r == 8'h0) return 8'hFF;
        while (p < int'(r)) p = p * 2;
        return 8'(p - 1);
    endfunction

    logic [15:0] m_state[2]     = '{SEED, SEED};
    int          m_busy_left[2] = '{0, 0};
    logic        m_valid[2]     = '{1'b0, 1'b0};
    logic [7:0]  m_value[2]     = '{8'h0, 8'h0};
    logic [7:0]  m_pend[2]      = '{8'h0, 8'h0};
    int          m_max_tries[2] = '{4, 1};

    // At each request the whole draw is played out on the upcoming state sequence.
    initial begin : model
        logic [15:0] s;
        logic [7:0]  c;
        logic        was_busy;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_state[i]     = SEED;
                    m_busy_left[i] = 0;
                    m_valid[i]     = 1'b0;
                    m_value[i]     = 8'h0;
                end else begin
                    was_busy = (m_busy_left[i] > 0);
                    if (load) m_state[i] = (seed_in == 16'h0) ? SEED : seed_in;
                    else if (en || was_busy) m_state[i] = lfsr_next(m_state[i]);
                    m_valid[i] = 1'b0;
                    if (was_busy) begin
                        m_busy_left[i]--;
                        if (m_busy_left[i] == 0) begin
                            m_valid[i] = 1'b1;
                            m_value[i] = m_pend[i];
                        end
                    end else if (req) begin
                        s = m_state[i];
                        for (int k = 0; k < m_max_tries[i]; k++) begin
                            c = s[7:0] & draw_mask(range);
                            if (range == 8'h0 || c < range) begin
                                m_pend[i]      = c;
                                m_busy_left[i] = k + 1;
                                break;
                            end
                            if (k == m_max_tries[i] - 1) begin
                                m_pend[i]      = c - range;
                                m_busy_left[i] = k + 1;
                            end
                            s = lfsr_next(s);
                        end
                    end
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            chk("state0", state0, m_state[0]);
            chk("busy0", busy0, m_busy_left[0] > 0);
            chk("valid0", valid0, m_valid[0]);
            chk("value0", value0, m_value[0]);
            chk("state1", state1, m_state[1]);
            chk("busy1", busy1, m_busy_left[1] > 0);
            chk("valid1", valid1, m_valid[1]);
            chk("value1", value1, m_value[1]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20; k++) begin
            if (!busy0 && !busy1) break;
            step(1);
        end
        chk("idle_timeout", {31'h0, busy0 | busy1}, 32'h0);
    endtask

    task automatic wait_valid0(input string name);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (valid0) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, {31'h0, seen}, 32'h1);
    endtask

    initial begin : stim
        logic [7:0] ranges[8];
        ranges = '{8'd1, 8'd2, 8'd7, 8'd8, 8'd100, 8'd128, 8'd200, 8'd255};

        step(2);
        chk("rst_state", state0, 16'hACE1);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_valid", valid0, 1'b0);
        chk("rst_value", value0, 8'h0);

        rst_n = 1'b1;
        en    = 1'b1;
        step(1);
        chk("step1", state0, 16'h59C3);
        step(1);
        chk("step2", state0, 16'hB387);
        en = 1'b0;

        load = 1'b1; seed_in = 16'h0000;
        step(1);
        chk("load_zero", state0, 16'hACE1);
        seed_in = 16'h0001; en = 1'b1;
        step(1);
        chk("load_wins", state0, 16'h0001);
        load = 1'b0; en = 1'b0;

        range = 8'd3; req = 1'b1;
        step(1);
        req = 1'b0;
        chk("d1_busy", busy0, 1'b1);
        step(1);
        chk("d1_valid", valid0, 1'b1);
        chk("d1_value", value0, 8'd1);
        chk("d1_idle", busy0, 1'b0);
        step(1);
        chk("d1_pulse", valid0, 1'b0);

        load = 1'b1; seed_in = 16'h0003;
        step(1);
        load = 1'b0; range = 8'd3; req = 1'b1;
        step(1);
        req = 1'b0;
        chk("d2_busy", busy0, 1'b1);
        step(1);
        chk("d2_state", state0, 16'h0006);
        chk("d2_busy2", busy0, 1'b1);
        chk("d2_novalid", valid0, 1'b0);
        chk("fb_valid", valid1, 1'b1);
        chk("fb_value", value1, 8'd0);
        step(1);
        chk("d2_valid", valid0, 1'b1);
        chk("d2_value", value0, 8'd2);
        step(1);

        load = 1'b1; seed_in = 16'h1234;
        step(1);
        load = 1'b0; range = 8'd0; req = 1'b1;
        step(1);
        req = 1'b0;
        step(1);
        chk("r0_valid0", valid0, 1'b1);
        chk("r0_value0", value0, 8'h34);
        chk("r0_value1", value1, 8'h34);

        // Held req gives back-to-back draws; range changes mid-draw must not matter.
        en = 1'b1; range = 8'd5; req = 1'b1;
        step(1);
        range = 8'd1;
        step(6);
        range = 8'd200;
        step(6);
        req = 1'b0; range = 8'd0; en = 1'b0;
        wait_idle();

        foreach (ranges[j]) begin
            en = 1'b1;
            step(j % 3 + 1);
            en = 1'b0;
            range = ranges[j]; req = 1'b1;
            step(1);
            req = 1'b0;
            wait_valid0("draw_done");
            chk("in_range", {31'h0, value0 < ranges[j]}, 32'h1);
            wait_idle();
        end

        load = 1'b1; seed_in = 16'h0003;
        step(1);
        load = 1'b0; range = 8'd3; req = 1'b1;
        step(1);
        req = 1'b0;
        chk("abort_busy_pre", busy0, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 1'b0);
        chk("abort_valid", valid0, 1'b0);
        chk("abort_state", state0, 16'hACE1);
        chk("abort_busy1", busy1, 1'b0);
        step(1);
        rst_n = 1'b1;
        step(2);
        chk("abort_novalid", valid0, 1'b0);
        range = 8'd3; req = 1'b1;
        step(1);
        req = 1'b0;
        wait_valid0("post_abort_draw");
        wait_idle();
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
